// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, next-PC select
// Optional PC_ALIGN_CHECK_EN: halt with sticky misalign_fault on misaligned next PC.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  input  logic            instr_ack,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  output logic [31:0]     fetch_count,
  output logic            misalign_fault
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            drop_pending;
  logic [XLEN-1:0] pc_next;
  logic            ack_take;
  logic            misalign;

  assign PCPlus4  = PC + FOUR;
  assign ack_take = (state == S_HOLD) && instr_ack;

  always_comb begin
    pc_next = PCPlus4;
    if (jalr)
      pc_next = {ALUResult[XLEN-1:1], 1'b0};
    else if (Branch || Jump)
      pc_next = PCTarget;
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = (pc_next[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_REQ;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_REQ:  if (imem_req_ready) state_next = S_WAIT;
      S_WAIT: if (imem_rsp_valid && !drop_pending) state_next = S_HOLD;
      S_HOLD: if (instr_ack) state_next = misalign ? S_HALT : S_REQ;
      S_HALT: state_next = S_HALT;
      default: state_next = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == S_REQ);
    imem_addr      = PC;
    instr_valid    = (state == S_HOLD);
  end

  // A response already in flight when reset hits WAIT belongs to the old PC; swallow it.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC           <= RESET_PC;
      Instr        <= NOP;
      fetch_count  <= 32'd0;
      drop_pending <= (state == S_WAIT) && !imem_rsp_valid;
    end else begin
      if (state == S_WAIT && imem_rsp_valid) begin
        if (drop_pending)
          drop_pending <= 1'b0;
        else
          Instr <= imem_rdata;
      end
      if (ack_take && !misalign) begin
        PC          <= pc_next;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)
      misalign_fault <= 1'b0;
    else if (ack_take && misalign)
      misalign_fault <= 1'b1;
  end
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_ack;
  logic        Branch;
  logic        Jump;
  logic        jalr;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic [31:0] fetch_count;
  logic        misalign_fault;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .instr_ack(instr_ack), .Branch(Branch), .Jump(Jump), .jalr(jalr),
    .PCTarget(PCTarget), .ALUResult(ALUResult),
    .fetch_count(fetch_count), .misalign_fault(misalign_fault)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_instr_q[$];
  bit          auto_ack = 1'b0;
  bit          mem_en = 1'b1;
  logic        acc;
  logic [31:0] acc_addr;
  logic        prev_iv = 1'b0;
  logic [31:0] base_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every accepted request and every newly presented instruction is scored.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      if (imem_req_valid && imem_req_ready) begin
        if (exp_addr_q.size() == 0) flag("unexpected_request");
        else check("req_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (instr_valid && !prev_iv) begin
        if (exp_instr_q.size() == 0) flag("unexpected_instr");
        else begin
          e = exp_instr_q.pop_front();
          check("instr_pc", PC, e[63:32]);
          check("instr_word", Instr, e[31:0]);
        end
      end
    end
    prev_iv = instr_valid;
  end

  task automatic tick();
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    #1;
    if (mem_en) begin
      imem_rsp_valid = acc;
      imem_rdata = acc ? (32'h0050_0093 + acc_addr) : 32'h0;
    end
    if (auto_ack) instr_ack = instr_valid;
  endtask

  task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] word);
    exp_addr_q.push_back(addr);
    exp_instr_q.push_back({addr, word});
  endtask

  task automatic wait_hold();
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    if (!instr_valid) flag("hold_timeout");
  endtask

  task automatic ack_with(input logic br, input logic jp, input logic jr,
                          input logic [31:0] tgt, input logic [31:0] alu);
    Branch = br; Jump = jp; jalr = jr; PCTarget = tgt; ALUResult = alu;
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    Branch = 1'b0; Jump = 1'b0; jalr = 1'b0;
  endtask

  task automatic step(input logic [31:0] addr, input logic [31:0] word, input logic br,
                      input logic jp, input logic jr, input logic [31:0] tgt, input logic [31:0] alu);
    expect_fetch(addr, word);
    wait_hold();
    ack_with(br, jp, jr, tgt, alu);
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = 32'h0;
    instr_ack = 1'b0; Branch = 1'b0; Jump = 1'b0; jalr = 1'b0;
    PCTarget = 32'h0; ALUResult = 32'h0;
    repeat (2) tick();
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", Instr, 32'h0000_0013);
    check("rst_pc", PC, 32'h0);
    check("rst_pcplus4", PCPlus4, 32'h4);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_misalign", {31'b0, misalign_fault}, 32'd0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);

    // Back-to-back fetches with immediate ack: one instruction per 3 cycles.
    expect_fetch(32'h0, 32'h0050_0093);
    expect_fetch(32'h4, 32'h0050_0097);
    expect_fetch(32'h8, 32'h0050_009B);
    imem_req_ready = 1'b1; auto_ack = 1'b1; reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("iv_cadence", {31'b0, instr_valid}, (k % 3 == 2) ? 32'd1 : 32'd0);
    end
    check("seq_fetch_count", fetch_count, 32'd3);
    check("seq_pc", PC, 32'hC);
    imem_req_ready = 1'b0; auto_ack = 1'b0; instr_ack = 1'b0;

    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("bp_addr", imem_addr, 32'hC);
    end
    expect_fetch(32'hC, 32'h0050_009F);
    imem_req_ready = 1'b1;
    tick();
    check("bp_wait_after_ready", {31'b0, imem_req_valid}, 32'd0);
    wait_hold();
    ack_with(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    step(32'h10, 32'h0050_00A3, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    step(32'h40, 32'h0050_00D3, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    step(32'h10, 32'h0050_00A3, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    step(32'h14, 32'h0050_00A7, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    expect_fetch(32'h20, 32'h0050_00B3);
    wait_hold();
    check("jalr_pcplus4", PCPlus4, 32'h24);
    ack_with(1'b0, 1'b1, 1'b1, 32'h80, 32'h101);
    step(32'h100, 32'h0050_0193, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    expect_fetch(32'hFFFF_FFFC, 32'h0050_008F);
    wait_hold();
    check("wrap_pcplus4", PCPlus4, 32'h0);
    ack_with(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_fetch(32'h0, 32'h0050_0093);
    wait_hold();
    check("pre_misalign_count", fetch_count, 32'd11);
    ack_with(1'b0, 1'b1, 1'b0, 32'h42, 32'h0);

`ifdef PC_ALIGN_CHECK_EN
    repeat (4) tick();
    check("halt_fault", {31'b0, misalign_fault}, 32'd1);
    check("halt_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("halt_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("halt_pc", PC, 32'h0);
    check("halt_count", fetch_count, 32'd11);
    imem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("halt_fault_cleared", {31'b0, misalign_fault}, 32'd0);
    base_addr = 32'h0;
`else
    check("no_check_fault", {31'b0, misalign_fault}, 32'd0);
    step(32'h42, 32'h0050_00D5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("final_count", fetch_count, 32'd13);
    base_addr = 32'h46;
`endif

    // Reset lands while a response is outstanding; the late word must never reach Instr.
    mem_en = 1'b0;
    imem_rsp_valid = 1'b0;
    exp_addr_q.push_back(base_addr);
    imem_req_ready = 1'b1;
    tick();
    check("stale_in_wait", {31'b0, imem_req_valid}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_fetch(32'h0, 32'h0050_0093);
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("stale_dropped_iv", {31'b0, instr_valid}, 32'd0);
    imem_rdata = 32'h0050_0093;
    tick();
    imem_rsp_valid = 1'b0;
    check("post_reset_iv", {31'b0, instr_valid}, 32'd1);
    check("post_reset_count", fetch_count, 32'd0);
    ack_with(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) tick();
    check("addr_q_empty", exp_addr_q.size(), 32'd0);
    check("instr_q_empty", exp_instr_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
